kpn_adder_process: RTL and testbench
====================================

Name: kpn_adder_process

Overview:
- KPN process node that sits directly downstream of two input FIFOs and upstream of one output FIFO.
- Repeats a fixed cycle: blocking read of token A, blocking read of token B, add them, then blocking write of the sum.
- Input FIFOs are first-word-fall-through: head word is valid whenever empty=0, and a one-cycle rd pulse pops it.
- The output FIFO accepts a word on a one-cycle wr pulse when full=0.

Parameters:
- BITS_NUMBER, 16, token width in bits for inputs, sum and output.
- SATURATE, 0, 0 = sum wraps modulo 2**BITS_NUMBER; 1 = unsigned saturation at 2**BITS_NUMBER-1.
- COUNT_BITS, 16, width of the emitted-token counter.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- empty_a, input, 1, input FIFO A empty flag.
- data_a, input, BITS_NUMBER, head word of FIFO A.
- rd_a, output, 1, pop strobe to FIFO A.
- empty_b, input, 1, input FIFO B empty flag.
- data_b, input, BITS_NUMBER, head word of FIFO B.
- rd_b, output, 1, pop strobe to FIFO B.
- full_out, input, 1, output FIFO full flag.
- wr_out, output, 1, push strobe to output FIFO.
- data_out, output, BITS_NUMBER, word presented to output FIFO.
- busy, output, 1, high when state is not GET_A.
- token_count, output, COUNT_BITS, number of sums written; wraps.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (async assert, sync-safe release): state=GET_A; a_reg=0; sum_reg=0; data_out=0; token_count=0. rd_a, rd_b, wr_out and busy are all 0 while in reset.
- FSM states: GET_A, GET_B, COMPUTE, PUT.
- GET_A: rd_a = ~empty_a (combinational). On an edge with empty_a=0: a_reg<=data_a, go to GET_B. Otherwise stay.
- GET_B: rd_b = ~empty_b. On an edge with empty_b=0: b_reg<=data_b, go to COMPUTE. Otherwise stay.
- COMPUTE: sum_reg <= a_reg + b_reg computed at BITS_NUMBER+1 bits.
  - SATURATE=0: keep the low BITS_NUMBER bits.
  - SATURATE=1: if the carry bit is set, load all-ones.
  - Always advances to PUT.
- PUT: wr_out = ~full_out. On an edge with full_out=0: token_count++, go to GET_A. Otherwise stay; backpressure is unbounded.
- data_out = sum_reg at all times. It is stable throughout PUT and holds after the write.
- Strobes: rd_a, rd_b and wr_out are each at most one cycle per token. rd_* is never asserted while its empty flag is high, because the FIFO pops on {wr,rd}=11 even when empty. wr_out is never asserted while full_out is high.
- Ordering: strict KPN blocking order A then B. Tokens on B are not consumed until A has been consumed, even if B is non-empty first.
- Throughput: 4 cycles per token when all FIFOs are ready. Latency from FIFO A pop to wr_out is 3 cycles.
- Counter: token_count wraps from 2**COUNT_BITS-1 to 0.
- Reset mid-operation: any token already popped but not yet written is discarded. The FSM restarts at GET_A. Loss is accepted; the system resets all FIFOs together.
- Empty/full flags are sampled only in their own state. Changes in other states have no effect.

Decomposition:
- Shared package kpn_pkg:
  - state encoding constants for GET_A, GET_B, COMPUTE, PUT (2-bit);
  - default BITS_NUMBER = 16.
- One natural sub-module: kpn_sat_adder. It is combinational (a, b, SATURATE) -> sum, and is reused by other arithmetic KPN nodes. FSM, registers and counter stay in the top module.

Test Plan:
- Basic: A=0x0003, B=0x0004 preloaded, full_out=0 -> rd_a one cycle, rd_b next cycle, wr_out on 4th cycle with data_out=0x0007; token_count=1.
- Wrap vs saturate: A=0xFFFF, B=0x0002 -> SATURATE=0 gives data_out=0x0001; SATURATE=1 gives 0xFFFF.
- Blocking read: A holds 5, B empty for 10 cycles, then B=6 -> rd_a once, no rd_b while empty_b=1, busy=1 throughout, then data_out=11 exactly once.
- Backpressure: full_out=1 for 7 cycles in PUT -> wr_out=0 and data_out stable; full_out drops -> single wr_out pulse, token_count increments by 1.
- Streaming: 8 token pairs (i, 2i) with FIFOs never empty or full -> outputs 3i in order, one wr_out every 4 cycles, token_count=8.
- Async reset in COMPUTE: assert rst_n=0 between edges -> rd/wr=0 and data_out=0 immediately, state GET_A. Next pair A=1, B=1 -> output 2, with no stale value written.

Source files
------------

// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN process nodes: FSM state encoding and default token width.
package kpn_pkg;

  localparam int DEFAULT_BITS_NUMBER = 16;

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    COMPUTE = 2'd2,
    PUT     = 2'd3
  } state_t;

endpackage

// File: rtl/kpn_adder_process_if.sv
// FIFO-side signal bundle of a two-input, one-output KPN node.
// master = the process node; slave = the FIFO fabric around it.
interface kpn_adder_process_if
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = DEFAULT_BITS_NUMBER
);

  logic                   empty_a;
  logic [BITS_NUMBER-1:0] data_a;
  logic                   rd_a;
  logic                   empty_b;
  logic [BITS_NUMBER-1:0] data_b;
  logic                   rd_b;
  logic                   full_out;
  logic                   wr_out;
  logic [BITS_NUMBER-1:0] data_out;

  modport master (
    input  empty_a, data_a, empty_b, data_b, full_out,
    output rd_a, rd_b, wr_out, data_out
  );

  modport slave (
    output empty_a, data_a, empty_b, data_b, full_out,
    input  rd_a, rd_b, wr_out, data_out
  );

endinterface

// File: rtl/kpn_sat_adder.sv
// Combinational unsigned adder with optional saturation at the all-ones value;
// shared by the arithmetic KPN nodes.
module kpn_sat_adder
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = DEFAULT_BITS_NUMBER,
  parameter bit SATURATE    = 1'b0
) (
  input  logic [BITS_NUMBER-1:0] a,
  input  logic [BITS_NUMBER-1:0] b,
  output logic [BITS_NUMBER-1:0] sum
);

  logic [BITS_NUMBER:0] wide;

  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    if (SATURATE && wide[BITS_NUMBER]) begin
      sum = '1;
    end else begin
      sum = wide[BITS_NUMBER-1:0];
    end
  end

endmodule

// File: rtl/kpn_adder_process.sv
// KPN process node: blocking read of A, blocking read of B, add, blocking write of the sum.
// One token per four cycles when every FIFO is ready.
module kpn_adder_process
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = DEFAULT_BITS_NUMBER,
  parameter bit SATURATE    = 1'b0,
  parameter int COUNT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  kpn_adder_process_if.master   fifo,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] token_count
);

  state_t                 state;
  state_t                 state_next;
  logic [BITS_NUMBER-1:0] a_reg;
  logic [BITS_NUMBER-1:0] b_reg;
  logic [BITS_NUMBER-1:0] sum_reg;
  logic [BITS_NUMBER-1:0] sum_next;
  logic                   rd_a;
  logic                   rd_b;
  logic                   wr_out;

  kpn_sat_adder #(
    .BITS_NUMBER (BITS_NUMBER),
    .SATURATE    (SATURATE)
  ) u_adder (
    .a   (a_reg),
    .b   (b_reg),
    .sum (sum_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GET_A;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    rd_a       = 1'b0;
    rd_b       = 1'b0;
    wr_out     = 1'b0;
    unique case (state)
      GET_A: begin
        rd_a = ~fifo.empty_a;
        if (!fifo.empty_a) state_next = GET_B;
      end
      GET_B: begin
        rd_b = ~fifo.empty_b;
        if (!fifo.empty_b) state_next = COMPUTE;
      end
      COMPUTE: begin
        state_next = PUT;
      end
      PUT: begin
        wr_out = ~fifo.full_out;
        if (!fifo.full_out) state_next = GET_A;
      end
      default: state_next = GET_A;
    endcase
  end

  // NOTE: strobes are masked by rst_n because GET_A is the reset state and
  // would otherwise pop FIFO A while reset is still held.
  assign fifo.rd_a     = rd_a & rst_n;
  assign fifo.rd_b     = rd_b & rst_n;
  assign fifo.wr_out   = wr_out & rst_n;
  assign fifo.data_out = sum_reg;
  assign busy          = (state != GET_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      token_count <= '0;
    end else begin
      if (rd_a) a_reg <= fifo.data_a;
      if (rd_b) b_reg <= fifo.data_b;
      if (state == COMPUTE) sum_reg <= sum_next;
      if (wr_out) token_count <= token_count + COUNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_kpn_adder_process.sv
// Directed plus randomized bench for kpn_adder_process: a wrapping and a saturating
// instance share one stimulus, checked against a token-level KPN reference model.
module tb_kpn_adder_process;
  import kpn_pkg::*;

  localparam int BITS   = 16;
  localparam int SAT_CB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            empty_a, empty_b, full_out;
  logic [BITS-1:0] data_a, data_b;
  logic            busy_w, busy_s;
  logic [15:0]     cnt_w;
  logic [SAT_CB-1:0] cnt_s;

  kpn_adder_process_if #(.BITS_NUMBER(BITS)) wif ();
  kpn_adder_process_if #(.BITS_NUMBER(BITS)) sif ();

  assign wif.empty_a  = empty_a;
  assign wif.data_a   = data_a;
  assign wif.empty_b  = empty_b;
  assign wif.data_b   = data_b;
  assign wif.full_out = full_out;
  assign sif.empty_a  = empty_a;
  assign sif.data_a   = data_a;
  assign sif.empty_b  = empty_b;
  assign sif.data_b   = data_b;
  assign sif.full_out = full_out;

  kpn_adder_process #(.BITS_NUMBER(BITS), .SATURATE(1'b0), .COUNT_BITS(16)) dut_wrap (
    .clk (clk), .rst_n (rst_n), .fifo (wif.master), .busy (busy_w), .token_count (cnt_w)
  );

  kpn_adder_process #(.BITS_NUMBER(BITS), .SATURATE(1'b1), .COUNT_BITS(SAT_CB)) dut_sat (
    .clk (clk), .rst_n (rst_n), .fifo (sif.master), .busy (busy_s), .token_count (cnt_s)
  );

  // FIFO contents, tokens popped but not yet written, and event bookkeeping
  logic [BITS-1:0] qa[$], qb[$], popped_a[$], popped_b[$];
  int              wr_cycles[$];
  bit              stall_a, stall_b, hold_full;
  int              n_cmp, n_err, cyc, n_rd_a, n_rd_b, n_wr, n_idle;
  int              rd_a_cyc, rd_b_cyc, last_wr_cyc;
  logic [BITS-1:0] last_w, last_s;

  function automatic logic [BITS-1:0] ref_sum(input logic [BITS-1:0] a, b, input bit sat);
    int unsigned s;
    s = int'(a) + int'(b);
    if (s > 65535) return sat ? 16'hFFFF : 16'(s - 65536);
    return 16'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    empty_a  = stall_a || (qa.size() == 0);
    data_a   = (qa.size() > 0) ? qa[0] : '0;
    empty_b  = stall_b || (qb.size() == 0);
    data_b   = (qb.size() > 0) ? qb[0] : '0;
    full_out = hold_full;
  endtask

  task automatic push_pair(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    qa.push_back(a);
    qb.push_back(b);
    refresh();
  endtask

  // One clock: observe strobes mid-cycle, then apply the FIFO pops they cause.
  task automatic tick();
    logic ra, rb, ww;
    logic [BITS-1:0] ta, tb;
    @(negedge clk);
    ra = wif.rd_a;
    rb = wif.rd_b;
    ww = wif.wr_out;
    check("rd_while_empty", {sif.rd_a & empty_a, sif.rd_b & empty_b, ra & empty_a, rb & empty_b}, 0);
    check("wr_while_full", {sif.wr_out & full_out, ww & full_out}, 0);
    if (!busy_w) n_idle++;
    if (ra && qa.size() > 0) begin
      popped_a.push_back(qa[0]);
      n_rd_a++;
      rd_a_cyc = cyc;
    end
    if (rb && qb.size() > 0) begin
      popped_b.push_back(qb[0]);
      n_rd_b++;
      rd_b_cyc = cyc;
    end
    if (ww) begin
      if (popped_a.size() == 0 || popped_b.size() == 0) begin
        check("wr_without_tokens", 1, 0);
      end else begin
        ta = popped_a.pop_front();
        tb = popped_b.pop_front();
        check("data_out_wrap", wif.data_out, ref_sum(ta, tb, 1'b0));
        check("data_out_sat", sif.data_out, ref_sum(ta, tb, 1'b1));
      end
      last_w = wif.data_out;
      last_s = sif.data_out;
      n_wr++;
      last_wr_cyc = cyc;
      wr_cycles.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ra && qa.size() > 0) void'(qa.pop_front());
    if (rb && qb.size() > 0) void'(qb.pop_front());
    refresh();
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_wr < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, n_wr, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra0, rb0, idle0, wr0, changes, bad, k;
    logic [BITS-1:0] d0;
    n_cmp = 0; n_err = 0; cyc = 0; n_rd_a = 0; n_rd_b = 0; n_wr = 0; n_idle = 0;
    rd_a_cyc = 0; rd_b_cyc = 0; last_wr_cyc = 0; last_w = '0; last_s = '0;
    stall_a = 0; stall_b = 0; hold_full = 0;
    rst_n = 1'b0;
    push_pair(16'h0003, 16'h0004);
    #12;

    // Reset state, with A non-empty so the rd_a mask is exercised
    check("reset_strobes", {wif.rd_a, wif.rd_b, wif.wr_out, sif.rd_a, sif.rd_b, sif.wr_out}, 0);
    check("reset_busy", {busy_w, busy_s}, 0);
    check("reset_data_out", {wif.data_out, sif.data_out}, 0);
    check("reset_count", {cnt_w, 13'(cnt_s)}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic: 3 + 4, latency and throughput framing
    wait_writes("basic_write", 1, 20);
    check("basic_rd_b_latency", rd_b_cyc - rd_a_cyc, 1);
    check("basic_wr_latency", last_wr_cyc - rd_a_cyc, 3);
    check("basic_data", last_w, 16'h0007);
    check("basic_count", cnt_w, 1);

    // Wrap vs saturate
    push_pair(16'hFFFF, 16'h0002);
    wait_writes("wrap_write", 2, 20);
    check("wrap_data", last_w, 16'h0001);
    check("sat_data", last_s, 16'hFFFF);

    // Blocking read: B empty for 10 cycles after A is taken
    ra0 = n_rd_a; rb0 = n_rd_b;
    qa.push_back(16'd5);
    refresh();
    tick();
    idle0 = n_idle;
    repeat (10) tick();
    check("block_rd_a_once", n_rd_a - ra0, 1);
    check("block_no_rd_b", n_rd_b - rb0, 0);
    check("block_busy", n_idle - idle0, 0);
    check("block_no_wr", n_wr, 2);
    qb.push_back(16'd6);
    refresh();
    wait_writes("block_write", 3, 20);
    check("block_data", last_w, 16'd11);
    repeat (6) tick();
    check("block_single_wr", n_wr, 3);

    // Backpressure: output full for 7 cycles while in PUT
    hold_full = 1'b1;
    push_pair(16'd100, 16'd200);
    repeat (4) tick();
    d0 = wif.data_out;
    check("bp_value", d0, 16'd300);
    wr0 = n_wr;
    changes = 0;
    repeat (7) begin
      tick();
      if (wif.data_out !== d0) changes++;
    end
    check("bp_no_wr", n_wr, wr0);
    check("bp_stable", changes, 0);
    hold_full = 1'b0;
    refresh();
    wait_writes("bp_write", 4, 10);
    check("bp_data", last_w, 16'd300);
    check("bp_count", cnt_w, 4);

    // Streaming 8 pairs (i, 2i): one write every 4 cycles
    wr_cycles.delete();
    for (int i = 1; i <= 8; i++) push_pair(16'(i), 16'(2 * i));
    wait_writes("stream_writes", 12, 60);
    bad = 0;
    for (int j = 1; j < wr_cycles.size(); j++)
      if (wr_cycles[j] - wr_cycles[j-1] != 4) bad++;
    check("stream_n", wr_cycles.size(), 8);
    check("stream_gap", bad, 0);
    check("stream_last", last_w, 16'd24);
    check("stream_count", cnt_w, 12);
    check("sat_count_wrap", cnt_s, 12 % 8);

    // Randomized values with random empty/full stalls
    for (int i = 0; i < 40; i++) push_pair(16'($urandom), 16'($urandom));
    k = 0;
    while (n_wr < 52 && k < 2000) begin
      stall_a   = ($urandom_range(0, 2) == 0);
      stall_b   = ($urandom_range(0, 2) == 0);
      hold_full = ($urandom_range(0, 2) == 0);
      refresh();
      tick();
      k++;
    end
    stall_a = 0; stall_b = 0; hold_full = 0;
    refresh();
    check("rand_writes", n_wr, 52);
    check("rand_count_wrap", cnt_w, 52);
    check("rand_count_sat", cnt_s, 52 % 8);

    // Async reset while in COMPUTE: in-flight token is dropped
    push_pair(16'd9, 16'd9);
    rb0 = n_rd_b;
    k = 0;
    while (n_rd_b == rb0 && k < 10) begin
      tick();
      k++;
    end
    check("arst_reached_compute", n_rd_b - rb0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobes", {wif.rd_a, wif.rd_b, wif.wr_out, sif.rd_a, sif.rd_b, sif.wr_out}, 0);
    check("arst_data_out", {wif.data_out, sif.data_out}, 0);
    check("arst_busy", {busy_w, busy_s}, 0);
    check("arst_count", {cnt_w, 13'(cnt_s)}, 0);
    popped_a.delete();
    popped_b.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    wr0 = n_wr;
    push_pair(16'd1, 16'd1);
    wait_writes("arst_write", wr0 + 1, 20);
    check("arst_data", last_w, 16'd2);
    check("arst_count_after", cnt_w, 1);
    repeat (5) tick();
    check("arst_no_stale_wr", n_wr, wr0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
